// File: rtl/fft_meter_pkg.sv
// Shared types, limits and the saturating adder for the FFT band level meter.
package fft_meter_pkg;

  // Frame-tracking state of the band accumulator
  typedef enum logic [0:0] {
    WAIT_SOP = 1'b0,
    ACCUM    = 1'b1
  } meter_state_e;

  // Default widths and the limits they imply
  localparam int SUM_W_DEF = 13;
  localparam int LVL_W_DEF = 4;
  localparam int SUM_MAX   = (1 << SUM_W_DEF) - 1;
  localparam int LVL_MAX   = (1 << LVL_W_DEF) - 1;

  // Result of a saturating add: clipped value plus an overflow flag
  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_sum_t;

  // a + b clipped to max_v; sat is set when clipping happened
  function automatic sat_sum_t sat_add(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] max_v);
    logic [32:0] full;
    sat_sum_t    r;
    full = {1'b0, a} + {1'b0, b};
    if (full > {1'b0, max_v}) begin
      r.sat = 1'b1;
      r.val = max_v;
    end else begin
      r.sat = 1'b0;
      r.val = full[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_level_meter_quant.sv
// Converts each completed frame sum into a 4-bit display level with
// peak-hold and a slow, one-step-per-N-frames decay.
module level_quant_hold
  import fft_meter_pkg::*;
#(
  parameter int SUM_W        = SUM_W_DEF,
  parameter int LVL_W        = LVL_W_DEF,
  parameter int SHIFT        = 9,
  parameter int DECAY_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] sum_i,
  input  logic             sum_valid_i,
  output logic [LVL_W-1:0] set_value_o,
  output logic             level_valid_o
);

  localparam int LVL_LIM = (1 << LVL_W) - 1;
  // Counter only needs to reach DECAY_FRAMES-1
  localparam int DCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [SUM_W-1:0] shifted_s;
  logic [LVL_W-1:0] raw_d, raw_q;
  logic             raw_valid_q;
  logic [LVL_W-1:0] set_d, set_q;
  logic [DCW-1:0]   dcnt_d, dcnt_q;
  logic             lv_d, lv_q;

  // Shift the frame sum down and clip it to the top level
  always_comb begin
    shifted_s = sum_i >> SHIFT;
    if (shifted_s > SUM_W'(LVL_LIM)) begin
      raw_d = LVL_W'(LVL_LIM);
    end else begin
      raw_d = shifted_s[LVL_W-1:0];
    end
  end

  // Register the clipped raw level one cycle after the sum arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
    end else begin
      raw_valid_q <= sum_valid_i;
      if (sum_valid_i) begin
        raw_q <= raw_d;
      end else begin
        raw_q <= raw_q;
      end
    end
  end

  // Peak-hold: rise at once, fall by one only after DECAY_FRAMES lower frames
  always_comb begin
    set_d  = set_q;
    dcnt_d = dcnt_q;
    lv_d   = raw_valid_q;
    if (raw_valid_q) begin
      if (raw_q >= set_q) begin
        set_d  = raw_q;
        dcnt_d = '0;
      end else if (DECAY_FRAMES == 0) begin
        set_d  = raw_q;
        dcnt_d = '0;
      end else if ((32'(dcnt_q) + 32'd1) == 32'(DECAY_FRAMES)) begin
        set_d  = (set_q != '0) ? (set_q - LVL_W'(1)) : '0;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end else begin
      set_d  = set_q;
      dcnt_d = dcnt_q;
    end
  end

  // Hold register, decay counter and level strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q  <= '0;
      dcnt_q <= '0;
      lv_q   <= 1'b0;
    end else begin
      set_q  <= set_d;
      dcnt_q <= dcnt_d;
      lv_q   <= lv_d;
    end
  end

  assign set_value_o   = set_q;
  assign level_valid_o = lv_q;

endmodule

// File: rtl/fft_level_meter.sv
// Band level meter between the FFT core and the bar display driver:
// sums |re|+|im| over a bin range per frame and hands the sum to the
// quantise/peak-hold stage.
module fft_level_meter
  import fft_meter_pkg::*;
#(
  parameter int DW           = 8,
  parameter int IDXW         = 6,
  parameter int BIN_LO       = 1,
  parameter int BIN_HI       = 31,
  parameter int SUM_W        = SUM_W_DEF,
  parameter int LVL_W        = LVL_W_DEF,
  parameter int SHIFT        = 9,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   xk_valid,
  input  logic                   xk_sop,
  input  logic                   xk_eop,
  input  logic [IDXW-1:0]        xk_idx,
  input  logic signed [DW-1:0]   xk_re,
  input  logic signed [DW-1:0]   xk_im,
  output logic [SUM_W-1:0]       sum,
  output logic                   sum_valid,
  output logic                   sum_sat,
  output logic [LVL_W-1:0]       set_value,
  output logic                   level_valid,
  output logic                   frame_drop
);

  localparam logic [31:0] SUM_LIM = 32'((64'd1 << SUM_W) - 64'd1);

  // Stage 1 signals
  logic [DW-1:0] abs_re_s, abs_im_s, abs_re_q, abs_im_q;
  logic          in_range_s;
  logic          s1_valid_q, s1_sop_q, s1_eop_q, s1_inr_q;

  // Stage 2 / FSM signals
  logic [DW:0]      mag_s, add_s;
  meter_state_e     state_d, state_q;
  logic [SUM_W-1:0] acc_d, acc_q, sum_d, sum_q;
  logic             sat_d, sat_q, sum_sat_d, sum_sat_q;
  logic             sum_valid_d, sum_valid_q, drop_d, drop_q;
  sat_sum_t         load_res_s, acc_res_s;
  logic             unused_bits_s;

  // Magnitudes as unsigned DW-bit values; -2^(DW-1) maps to 2^(DW-1)
  always_comb begin
    abs_re_s   = xk_re[DW-1] ? DW'(-xk_re) : DW'(xk_re);
    abs_im_s   = xk_im[DW-1] ? DW'(-xk_im) : DW'(xk_im);
    in_range_s = (32'(xk_idx) >= 32'(BIN_LO)) && (32'(xk_idx) <= 32'(BIN_HI));
  end

  // Stage 1 register: magnitudes plus qualified frame markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_re_q   <= '0;
      abs_im_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_inr_q   <= 1'b0;
    end else begin
      abs_re_q   <= abs_re_s;
      abs_im_q   <= abs_im_s;
      s1_valid_q <= xk_valid;
      s1_sop_q   <= xk_valid & xk_sop;
      s1_eop_q   <= xk_valid & xk_eop;
      s1_inr_q   <= in_range_s;
    end
  end

  // Frame-tracking state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a sop opens a frame unless it also closes it; eop closes it
  always_comb begin
    state_d = state_q;
    if (s1_valid_q) begin
      case (state_q)
        WAIT_SOP: begin
          if (s1_sop_q && !s1_eop_q) state_d = ACCUM;
          else                       state_d = WAIT_SOP;
        end
        ACCUM: begin
          if (s1_eop_q) state_d = WAIT_SOP;
          else          state_d = ACCUM;
        end
        default: state_d = WAIT_SOP;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Accumulator update, frame completion and early-sop abort
  always_comb begin
    mag_s       = {1'b0, abs_re_q} + {1'b0, abs_im_q};
    add_s       = s1_inr_q ? mag_s : '0;
    load_res_s  = sat_add(32'd0, 32'(add_s), SUM_LIM);
    acc_res_s   = sat_add(32'(acc_q), 32'(add_s), SUM_LIM);
    acc_d       = acc_q;
    sat_d       = sat_q;
    sum_d       = sum_q;
    sum_sat_d   = sum_sat_q;
    sum_valid_d = 1'b0;
    drop_d      = 1'b0;
    if (s1_valid_q) begin
      case (state_q)
        WAIT_SOP: begin
          if (s1_sop_q) begin
            acc_d = load_res_s.val[SUM_W-1:0];
            sat_d = load_res_s.sat;
          end else begin
            acc_d = acc_q;
            sat_d = sat_q;
          end
        end
        ACCUM: begin
          if (s1_sop_q) begin
            drop_d = 1'b1;
            acc_d  = load_res_s.val[SUM_W-1:0];
            sat_d  = load_res_s.sat;
          end else begin
            acc_d = acc_res_s.val[SUM_W-1:0];
            sat_d = sat_q | acc_res_s.sat;
          end
        end
        default: begin
          acc_d = '0;
          sat_d = 1'b0;
        end
      endcase
      // eop closes a frame only if one is open or this sample opened it
      if (s1_eop_q && ((state_q == ACCUM) || s1_sop_q)) begin
        sum_d       = acc_d;
        sum_sat_d   = sat_d;
        sum_valid_d = 1'b1;
      end else begin
        sum_valid_d = 1'b0;
      end
    end else begin
      acc_d = acc_q;
      sat_d = sat_q;
    end
  end

  assign unused_bits_s = ^{load_res_s.val[31:SUM_W], acc_res_s.val[31:SUM_W]};

  // Accumulator and registered frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      sum_q       <= '0;
      sum_sat_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      sum_q       <= sum_d;
      sum_sat_q   <= sum_sat_d;
      sum_valid_q <= sum_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign sum        = sum_q;
  assign sum_sat    = sum_sat_q;
  assign sum_valid  = sum_valid_q;
  assign frame_drop = drop_q;

  level_quant_hold #(
    .SUM_W        (SUM_W),
    .LVL_W        (LVL_W),
    .SHIFT        (SHIFT),
    .DECAY_FRAMES (DECAY_FRAMES)
  ) u_quant (
    .clk           (clk),
    .rst_n         (rst_n),
    .sum_i         (sum_q),
    .sum_valid_i   (sum_valid_q),
    .set_value_o   (set_value),
    .level_valid_o (level_valid)
  );

endmodule

// File: tb/tb_fft_level_meter.sv
// Directed bench for fft_level_meter: default-range instance plus a
// full-range (bins 0..63) instance sharing the same input stream.
module tb_fft_level_meter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              xk_valid, xk_sop, xk_eop;
  logic [5:0]        xk_idx;
  logic signed [7:0] xk_re, xk_im;

  logic [12:0] sum, sum_w;
  logic        sum_valid, sum_valid_w, sum_sat, sum_sat_w;
  logic [3:0]  set_value, set_value_w;
  logic        level_valid, level_valid_w, frame_drop, frame_drop_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_level_meter dut (
    .clk(clk), .rst_n(rst_n), .xk_valid(xk_valid), .xk_sop(xk_sop),
    .xk_eop(xk_eop), .xk_idx(xk_idx), .xk_re(xk_re), .xk_im(xk_im),
    .sum(sum), .sum_valid(sum_valid), .sum_sat(sum_sat),
    .set_value(set_value), .level_valid(level_valid), .frame_drop(frame_drop)
  );

  fft_level_meter #(.BIN_LO(0), .BIN_HI(63)) dut_w (
    .clk(clk), .rst_n(rst_n), .xk_valid(xk_valid), .xk_sop(xk_sop),
    .xk_eop(xk_eop), .xk_idx(xk_idx), .xk_re(xk_re), .xk_im(xk_im),
    .sum(sum_w), .sum_valid(sum_valid_w), .sum_sat(sum_sat_w),
    .set_value(set_value_w), .level_valid(level_valid_w), .frame_drop(frame_drop_w)
  );

  // Cycle counter and output event recorder for the default instance
  int          cyc = 0;
  int          sv_cnt = 0, lv_cnt = 0, fd_cnt = 0, sv_cyc = 0, lv_cyc = 0;
  logic [12:0] last_sum = '0;
  logic        last_sat = 1'b0;
  int          lv_hist[0:255];
  int          eop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sum_valid === 1'b1) begin
      sv_cnt   <= sv_cnt + 1;
      sv_cyc   <= cyc;
      last_sum <= sum;
      last_sat <= sum_sat;
    end
    if (level_valid === 1'b1) begin
      lv_hist[lv_cnt & 255] <= int'(set_value);
      lv_cnt <= lv_cnt + 1;
      lv_cyc <= cyc;
    end
    if (frame_drop === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input int idx,
                       input int re, input int im);
    @(negedge clk);
    xk_valid = v;
    xk_sop   = s;
    xk_eop   = e;
    xk_idx   = 6'(idx);
    xk_re    = 8'(re);
    xk_im    = 8'(im);
    if (v && e) eop_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic frame(input int re, input int im, input int first, input int last,
                       input bit with_sop, input bit with_eop, input bit bub);
    for (int i = first; i <= last; i++) begin
      if (bub) idle($urandom_range(0, 2));
      drive(1'b1, with_sop && (i == first), with_eop && (i == last), i, re, im);
    end
  endtask

  int base, sv0, fd0;

  initial begin
    rst_n = 1'b0;
    xk_valid = 1'b0; xk_sop = 1'b0; xk_eop = 1'b0;
    xk_idx = '0; xk_re = '0; xk_im = '0;
    repeat (3) @(negedge clk);
    check_val("rst_sum", sum, 0);
    check_val("rst_sum_valid", sum_valid, 0);
    check_val("rst_sum_sat", sum_sat, 0);
    check_val("rst_set_value", set_value, 0);
    check_val("rst_level_valid", level_valid, 0);
    check_val("rst_frame_drop", frame_drop, 0);
    rst_n = 1'b1;
    idle(2);

    // eop with no preceding sop must not produce a sum
    frame(50, 50, 10, 20, 1'b0, 1'b1, 1'b1);
    idle(6);
    check_val("no_sop_no_sum", sv_cnt, 0);

    // Reference frame: 31 bins of 200 -> 6200, level 12
    frame(100, -100, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("ref_sum_cnt", sv_cnt, 1);
    check_val("ref_sum", last_sum, 6200);
    check_val("ref_sat", last_sat, 0);
    check_val("ref_sum_lat", sv_cyc - eop_cyc, 2);
    check_val("ref_lvl_lat", lv_cyc - eop_cyc, 4);
    check_val("ref_level", set_value, 12);
    check_val("ref_no_drop", fd_cnt, 0);

    // Same frame with random bubbles gives the same sum
    frame(100, -100, 0, 63, 1'b1, 1'b1, 1'b1);
    idle(8);
    check_val("bub_sum_cnt", sv_cnt, 2);
    check_val("bub_sum", last_sum, 6200);

    // Back-to-back silent frames decay the held level
    base = lv_cnt;
    sv0  = sv_cnt;
    for (int f = 0; f < 8; f++) frame(0, 0, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("b2b_sums", sv_cnt - sv0, 8);
    check_val("b2b_zero_sum", last_sum, 0);
    check_val("decay_f1", lv_hist[base & 255], 12);
    check_val("decay_f3", lv_hist[(base + 2) & 255], 12);
    check_val("decay_f4", lv_hist[(base + 3) & 255], 11);
    check_val("decay_f7", lv_hist[(base + 6) & 255], 11);
    check_val("decay_f8", lv_hist[(base + 7) & 255], 10);

    // Louder frame: 31*232 = 7192 -> level 14 at once
    frame(116, 116, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("rise_sum", last_sum, 7192);
    check_val("rise_level", set_value, 14);

    // Full-scale negative: full range saturates, default range does not
    frame(-128, -128, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("sat_w_sum", sum_w, 8191);
    check_val("sat_w_flag", sum_sat_w, 1);
    check_val("sat_w_level", set_value_w, 15);
    check_val("sat_d_sum", last_sum, 7936);
    check_val("sat_d_flag", last_sat, 0);
    check_val("sat_d_level", set_value, 15);

    // Saturation flag is per frame
    frame(0, 0, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("sat_clr_sum", sum_w, 0);
    check_val("sat_clr_flag", sum_sat_w, 0);

    // Early sop aborts the open frame exactly once
    fd0 = fd_cnt;
    sv0 = sv_cnt;
    frame(50, 50, 0, 19, 1'b1, 1'b0, 1'b0);
    frame(100, -100, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("drop_cnt", fd_cnt - fd0, 1);
    check_val("drop_sum_cnt", sv_cnt - sv0, 1);
    check_val("drop_sum", last_sum, 6200);

    // One-sample frames: sop and eop together
    drive(1'b1, 1'b1, 1'b1, 5, 3, -4);
    idle(6);
    check_val("one_sum", last_sum, 7);
    check_val("one_lat", sv_cyc - eop_cyc, 2);
    drive(1'b1, 1'b1, 1'b1, 0, 100, 100);
    idle(6);
    check_val("one_oor_sum", last_sum, 0);

    // Reset in the middle of a frame
    frame(100, -100, 0, 30, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    xk_valid = 1'b0;
    idle(2);
    check_val("mrst_sum", sum, 0);
    check_val("mrst_sum_valid", sum_valid, 0);
    check_val("mrst_sum_sat", sum_sat, 0);
    check_val("mrst_set_value", set_value, 0);
    check_val("mrst_level_valid", level_valid, 0);
    check_val("mrst_frame_drop", frame_drop, 0);
    rst_n = 1'b1;
    idle(2);
    fd0 = fd_cnt;
    frame(10, 10, 0, 63, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_val("post_rst_sum", last_sum, 620);
    check_val("post_rst_level", set_value, 1);
    check_val("post_rst_no_drop", fd_cnt - fd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", cyc, 0);
    $fatal(1);
  end

endmodule
